// File: rtl/sigmoid_lut_arbiter.sv
// ============================================================================
// Module   : sigmoid_lut_arbiter
// Purpose  : Round-robin sharing of one synchronous sigmoid LUT ROM among
//            N_REQ requesters, with index clamping and tagged response return.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sigmoid_lut_arbiter #(
  parameter int N_REQ      = 4,
  parameter int IN_W       = 64,
  parameter int OUT_W      = 64,
  parameter int ROM_DEPTH  = 500,
  parameter int ROM_OFFSET = 250,
  parameter int ROM_LAT    = 1,
  localparam int c_AW      = $clog2(ROM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*IN_W-1:0]   i_req_in,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [c_AW-1:0]         o_rom_addr,
  input  logic [OUT_W-1:0]        i_rom_data,
  output logic [N_REQ-1:0]        o_rsp_valid,
  output logic [OUT_W-1:0]        o_rsp_data,
  output logic                    o_rsp_sat,
  output logic                    o_busy
);

  localparam int c_IDW  = $clog2(N_REQ);
  // One stage aligned with rom_addr plus ROM_LAT stages of ROM read latency
  localparam int c_NSTG = ROM_LAT + 1;
  localparam logic [N_REQ-1:0] c_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [c_IDW-1:0]   r_rr_ptr;
  logic [c_AW-1:0]    r_rom_addr;
  logic [c_NSTG-1:0]  r_tag_vld;
  logic [c_IDW-1:0]   r_tag_id  [c_NSTG];
  logic [c_NSTG-1:0]  r_tag_sat;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [OUT_W-1:0]   r_rsp_data;
  logic               r_rsp_sat;

  logic               w_accept;
  logic [c_IDW-1:0]   w_gnt_id;
  logic [N_REQ-1:0]   w_grant;
  logic [IN_W-1:0]    w_sel_in;
  logic signed [IN_W:0] w_sum;
  logic [c_AW-1:0]    w_addr;
  logic               w_sat;

  function automatic logic [c_IDW-1:0] f_wrap(input int v);
    return c_IDW'(v % N_REQ);
  endfunction

  always_comb begin
    w_accept = 1'b0;
    w_gnt_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_accept && i_req_valid[f_wrap(int'(r_rr_ptr) + k)]) begin
        w_accept = 1'b1;
        w_gnt_id = f_wrap(int'(r_rr_ptr) + k);
      end
    end
    w_grant = w_accept ? (c_ONE << w_gnt_id) : '0;
  end

  // Sign-extend by one bit so adding the offset can never wrap
  always_comb begin
    w_sel_in = i_req_in[w_gnt_id*IN_W +: IN_W];
    w_sum    = $signed({w_sel_in[IN_W-1], w_sel_in}) + $signed((IN_W+1)'(ROM_OFFSET));
    if (w_sum < 0) begin
      w_addr = '0;
      w_sat  = 1'b1;
    end else if (w_sum > $signed((IN_W+1)'(ROM_DEPTH-1))) begin
      w_addr = c_AW'(ROM_DEPTH-1);
      w_sat  = 1'b1;
    end else begin
      w_addr = w_sum[c_AW-1:0];
      w_sat  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_rom_addr  <= '0;
      r_tag_vld   <= '0;
      r_tag_sat   <= '0;
      for (int s = 0; s < c_NSTG; s++) r_tag_id[s] <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_sat   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rr_ptr   <= f_wrap(int'(w_gnt_id) + 1);
        r_rom_addr <= w_addr;
      end
      r_tag_vld[0] <= w_accept;
      r_tag_id[0]  <= w_gnt_id;
      r_tag_sat[0] <= w_sat;
      for (int s = 1; s < c_NSTG; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
        r_tag_sat[s] <= r_tag_sat[s-1];
      end
      if (r_tag_vld[c_NSTG-1]) begin
        r_rsp_valid <= c_ONE << r_tag_id[c_NSTG-1];
        r_rsp_data  <= i_rom_data;
        r_rsp_sat   <= r_tag_sat[c_NSTG-1];
      end else begin
        r_rsp_valid <= '0;
      end
    end
  end

  assign o_req_ready = w_grant;
  assign o_rom_addr  = r_rom_addr;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_sat   = r_rsp_sat;
  assign o_busy      = (|r_tag_vld) | (|r_rsp_valid);

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_lut_arbiter.sv
// ============================================================================
// Module   : tb_sigmoid_lut_arbiter
// Purpose  : Directed, table-driven checks of sigmoid_lut_arbiter at ROM_LAT=1
//            and ROM_LAT=3 against a behavioural ROM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sigmoid_lut_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   valid1 = '0, valid2 = '0;
  logic [255:0] in1 = '0, in2 = '0;
  logic [3:0]   ready1, ready2, rspv1, rspv2;
  logic [8:0]   addr1, addr2;
  logic [63:0]  romd1, romd2, rspd1, rspd2;
  logic         sat1, sat2, busy1, busy2;
  logic [63:0]  rp0, rp1;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [63:0] rom_f(input logic [8:0] a);
    return 64'h3FE0_0000_0000_0000 + {55'b0, a} * 64'd4097;
  endfunction

  sigmoid_lut_arbiter #(.ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_req_valid(valid1), .i_req_in(in1), .o_req_ready(ready1),
    .o_rom_addr(addr1), .i_rom_data(romd1), .o_rsp_valid(rspv1), .o_rsp_data(rspd1),
    .o_rsp_sat(sat1), .o_busy(busy1));

  sigmoid_lut_arbiter #(.ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .i_req_valid(valid2), .i_req_in(in2), .o_req_ready(ready2),
    .o_rom_addr(addr2), .i_rom_data(romd2), .o_rsp_valid(rspv2), .o_rsp_data(rspd2),
    .o_rsp_sat(sat2), .o_busy(busy2));

  // Behavioural synchronous ROMs with 1 and 3 cycle read latency
  always @(posedge clk) begin
    romd1 <= rom_f(addr1);
    rp0   <= rom_f(addr2);
    rp1   <= rp0;
    romd2 <= rp1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_single(input int id, input logic [63:0] idx,
                           input logic [8:0] eaddr, input logic esat);
    valid1 = 4'b0001 << id;
    in1[id*64 +: 64] = idx;
    #1 chk("single_ready", ready1, 4'b0001 << id);
    tick();
    valid1 = '0;
    chk("single_addr", addr1, eaddr);
    chk("single_busy", busy1, 1);
    tick();
    chk("single_rsp_early", rspv1, 0);
    tick();
    chk("single_rspv", rspv1, 4'b0001 << id);
    chk("single_data", rspd1, rom_f(eaddr));
    chk("single_sat", sat1, esat);
  endtask

  typedef struct {
    logic [63:0] idx;
    logic [8:0]  addr;
    logic        sat;
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{64'd0,                     9'd250, 1'b0};
    vt[1] = '{-64'sd300,                 9'd0,   1'b1};
    vt[2] = '{-64'sd250,                 9'd0,   1'b0};
    vt[3] = '{64'd249,                   9'd499, 1'b0};
    vt[4] = '{64'd250,                   9'd499, 1'b1};
    vt[5] = '{64'h7FFF_FFFF_FFFF_FFFF,   9'd499, 1'b1};
    vt[6] = '{64'h8000_0000_0000_0000,   9'd0,   1'b1};
    vt[7] = '{64'd5,                     9'd255, 1'b0};

    do_reset();
    chk("rst_addr", addr1, 0);
    chk("rst_rspv", rspv1, 0);
    chk("rst_data", rspd1, 0);
    chk("rst_sat", sat1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_ready", ready1, 0);

    // Single requests through the clamp table
    for (int v = 0; v < 8; v++) do_single(0, vt[v].idx, vt[v].addr, vt[v].sat);
    tick();
    chk("idle_busy", busy1, 0);

    // All four requesters from rr_ptr=0
    do_reset();
    for (int i = 0; i < 4; i++) in1[i*64 +: 64] = 64'(i * 10);
    for (int t = 0; t < 6; t++) begin
      valid1 = (t < 4) ? 4'hF : 4'h0;
      #1;
      if (t < 4) chk("rr_ready", ready1, 4'b0001 << t);
      tick();
      if (t >= 2) begin
        chk("rr_rspv", rspv1, 4'b0001 << (t - 2));
        chk("rr_data", rspd1, rom_f(9'(250 + 10 * (t - 2))));
      end
    end

    // Fairness between requesters 1 and 3
    in1[1*64 +: 64] = 64'd1;
    in1[3*64 +: 64] = 64'd3;
    for (int t = 0; t < 8; t++) begin
      valid1 = (t < 6) ? 4'b1010 : 4'b0000;
      #1;
      if (t < 6) chk("fair_ready", ready1, (t % 2 == 0) ? 4'b0010 : 4'b1000);
      tick();
      if (t >= 2) begin
        chk("fair_rspv", rspv1, ((t - 2) % 2 == 0) ? 4'b0010 : 4'b1000);
        chk("fair_data", rspd1, rom_f(((t - 2) % 2 == 0) ? 9'd251 : 9'd253));
      end
    end

    // Reset while requester 2 is in flight
    tick();
    valid1 = 4'b0100;
    in1[2*64 +: 64] = 64'd0;
    #1 chk("mid_ready", ready1, 4'b0100);
    tick();
    valid1 = '0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_busy", busy1, 0);
    chk("mid_rspv", rspv1, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("mid_no_rsp", rspv1, 0);
    end
    valid1 = 4'hF;
    #1 chk("mid_ptr0", ready1, 4'b0001);
    do_single(0, 64'd7, 9'd257, 1'b0);

    // ROM_LAT=3 instance: back-to-back ids 0 and 1
    chk("lat3_busy0", busy2, 0);
    in2[0 +: 64]  = -64'sd10;
    in2[64 +: 64] = 64'd100;
    for (int t = 0; t < 7; t++) begin
      valid2 = (t < 2) ? 4'b0011 : 4'b0000;
      #1;
      if (t < 2) chk("lat3_ready", ready2, 4'b0001 << t);
      tick();
      if (t == 0) chk("lat3_addr0", addr2, 9'd240);
      if (t == 1) chk("lat3_addr1", addr2, 9'd350);
      chk("lat3_rspv", rspv2, (t == 4) ? 4'b0001 : (t == 5) ? 4'b0010 : 4'b0000);
      if (t == 4) chk("lat3_data0", rspd2, rom_f(9'd240));
      if (t == 5) chk("lat3_data1", rspd2, rom_f(9'd350));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
